// File: rtl/usr_rx_conn_app.sv
// Application stage after the fpga_core user RX port: opens NUM_CONN sessions, then drains header+payload frames into statistics.
// Optional build macro USR_RX_LEN_CHECK_EN: also flags frames whose byte count differs from the header length field.
module usr_rx_conn_app #(
  parameter int          NUM_CONN   = 4,
  parameter logic [15:0] CONN_BASE  = 16'd1,
  parameter int          DATA_WIDTH = 64,
  parameter int          KEEP_WIDTH = 8,
  parameter int          HDR_WIDTH  = 112
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HDR_WIDTH-1:0]  s_usr_hdr_data,
  input  logic                  s_usr_hdr_valid,
  output logic                  s_usr_hdr_ready,
  input  logic [DATA_WIDTH-1:0] s_usr_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_usr_payload_axis_tkeep,
  input  logic                  s_usr_payload_axis_tvalid,
  input  logic                  s_usr_payload_axis_tlast,
  input  logic                  s_usr_payload_axis_tuser,
  output logic                  s_usr_payload_axis_tready,
  output logic [15:0]           m_setconn_axis_tdata,
  output logic                  m_setconn_axis_tvalid,
  input  logic                  m_setconn_axis_tready,
  output logic [31:0]           pkt_count,
  output logic [31:0]           byte_count,
  output logic [15:0]           err_count,
  output logic [5:0]            led,
  output logic [0:0]            rx_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both 1; a source holds data and valid stable until that edge.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;
  localparam int         PW         = $clog2(KEEP_WIDTH + 1);

  logic                 run;
  logic [8:0]           conn_idx;
  logic [0:0]           state;
  logic [15:0]          frame_bytes;
  logic [HDR_WIDTH-1:0] hdr_q;
  logic [PW-1:0]        beat_bytes;
  logic [16:0]          frame_sum;
  logic [15:0]          frame_next;
  logic                 beat_fire;
  logic                 hdr_fire;
  logic                 err_now;
  logic                 unused_bits;

  function automatic logic [PW-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + PW'(k[i]);
    return c;
  endfunction

  // run gates every ready/valid so all outputs read 0 while reset is held.
  assign m_setconn_axis_tvalid     = run && (conn_idx < 9'(NUM_CONN));
  assign m_setconn_axis_tdata      = m_setconn_axis_tvalid ? (CONN_BASE + {7'd0, conn_idx}) : 16'd0;
  assign s_usr_hdr_ready           = run && (state == ST_IDLE);
  assign s_usr_payload_axis_tready = run && (state == ST_PAYLOAD);

  assign hdr_fire   = s_usr_hdr_valid && s_usr_hdr_ready;
  assign beat_fire  = s_usr_payload_axis_tvalid && s_usr_payload_axis_tready;
  assign beat_bytes = popcount(s_usr_payload_axis_tkeep);
  assign frame_sum  = {1'b0, frame_bytes} + 17'(beat_bytes);
  assign frame_next = frame_sum[16] ? 16'hFFFF : frame_sum[15:0];

`ifdef USR_RX_LEN_CHECK_EN
  assign err_now = s_usr_payload_axis_tuser || (frame_next != hdr_q[15:0]);
`else
  assign err_now = s_usr_payload_axis_tuser;
`endif

  // Payload data and the latched header are observed only for debug.
  assign unused_bits = ^{s_usr_payload_axis_tdata, hdr_q};

  assign led      = {err_count != 16'd0, pkt_count[4:0]};
  assign rx_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      conn_idx    <= '0;
      state       <= ST_IDLE;
      frame_bytes <= '0;
      hdr_q       <= '0;
      pkt_count   <= '0;
      byte_count  <= '0;
      err_count   <= '0;
    end else begin
      run <= 1'b1;
      if (m_setconn_axis_tvalid && m_setconn_axis_tready) conn_idx <= conn_idx + 9'd1;
      case (state)
        ST_IDLE: begin
          if (hdr_fire) begin
            hdr_q       <= s_usr_hdr_data;
            frame_bytes <= '0;
            state       <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (beat_fire) begin
            if (s_usr_payload_axis_tlast) begin
              pkt_count   <= pkt_count + 32'd1;
              byte_count  <= byte_count + {16'd0, frame_next};
              if (err_now && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
              frame_bytes <= '0;
              state       <= ST_IDLE;
            end else begin
              frame_bytes <= frame_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_rx_conn_app.sv
// Directed bench for usr_rx_conn_app: setup sequencer, frame statistics, error paths, reset mid-frame.
module tb_usr_rx_conn_app;

  logic         clk;
  logic         rst;
  logic [111:0] hdr_data;
  logic         hdr_valid;
  logic         hdr_ready;
  logic [63:0]  p_tdata;
  logic [7:0]   p_tkeep;
  logic         p_tvalid;
  logic         p_tlast;
  logic         p_tuser;
  logic         p_tready;
  logic [15:0]  sc_tdata;
  logic         sc_tvalid;
  logic         sc_tready;
  logic [31:0]  pkt_count;
  logic [31:0]  byte_count;
  logic [15:0]  err_count;
  logic [5:0]   led;
  logic [0:0]   rx_state;

  int n_cmp = 0;
  int n_bad = 0;

  usr_rx_conn_app dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_usr_hdr_data            (hdr_data),
    .s_usr_hdr_valid           (hdr_valid),
    .s_usr_hdr_ready           (hdr_ready),
    .s_usr_payload_axis_tdata  (p_tdata),
    .s_usr_payload_axis_tkeep  (p_tkeep),
    .s_usr_payload_axis_tvalid (p_tvalid),
    .s_usr_payload_axis_tlast  (p_tlast),
    .s_usr_payload_axis_tuser  (p_tuser),
    .s_usr_payload_axis_tready (p_tready),
    .m_setconn_axis_tdata      (sc_tdata),
    .m_setconn_axis_tvalid     (sc_tvalid),
    .m_setconn_axis_tready     (sc_tready),
    .pkt_count                 (pkt_count),
    .byte_count                (byte_count),
    .err_count                 (err_count),
    .led                       (led),
    .rx_state                  (rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic [15:0] len);
    logic ok;
    ok        = 1'b0;
    hdr_data  = {32'h0a000001, 32'h0a000002, 16'd1234, 16'd1, len};
    hdr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (hdr_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    hdr_valid = 1'b0;
    chk("hdr_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_beat(input logic [7:0] keep, input logic last, input logic user);
    logic ok;
    ok       = 1'b0;
    p_tdata  = {32'(keep), 32'hdead_beef};
    p_tkeep  = keep;
    p_tlast  = last;
    p_tuser  = user;
    p_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (p_tready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    p_tvalid = 1'b0;
    p_tlast  = 1'b0;
    p_tuser  = 1'b0;
    chk("beat_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_frame20(input logic [15:0] len, input logic user);
    send_hdr(len);
    send_beat(8'hFF, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b0, 1'b0);
    send_beat(8'h0F, 1'b1, user);
  endtask

  initial begin
    rst = 1'b1; hdr_data = '0; hdr_valid = 1'b0;
    p_tdata = '0; p_tkeep = '0; p_tvalid = 1'b0; p_tlast = 1'b0; p_tuser = 1'b0;
    sc_tready = 1'b1;
    repeat (3) step();

    // reset state
    chk("rst_pkt", pkt_count, 32'd0);
    chk("rst_byte", byte_count, 32'd0);
    chk("rst_err", {16'd0, err_count}, 32'd0);
    chk("rst_led", {26'd0, led}, 32'd0);
    chk("rst_sc_valid", {31'd0, sc_tvalid}, 32'd0);
    chk("rst_sc_data", {16'd0, sc_tdata}, 32'd0);
    chk("rst_hdr_ready", {31'd0, hdr_ready}, 32'd0);
    chk("rst_tready", {31'd0, p_tready}, 32'd0);
    chk("rst_state", {31'd0, rx_state}, 32'd0);

    // setup burst with tready held high: ids 1..4 on consecutive cycles
    rst = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      chk("sc_burst_valid", {31'd0, sc_tvalid}, 32'd1);
      chk("sc_burst_data", {16'd0, sc_tdata}, 32'(i));
      step();
    end
    repeat (3) begin
      chk("sc_done_valid", {31'd0, sc_tvalid}, 32'd0);
      step();
    end

    // setup with back-pressure on request 2
    rst = 1'b1; sc_tready = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("sc_bp_first", {16'd0, sc_tdata}, 32'd1);
    sc_tready = 1'b1;
    step();
    sc_tready = 1'b0;
    repeat (5) begin
      chk("sc_bp_hold_valid", {31'd0, sc_tvalid}, 32'd1);
      chk("sc_bp_hold_data", {16'd0, sc_tdata}, 32'd2);
      step();
    end
    sc_tready = 1'b1;
    chk("sc_bp_still2", {16'd0, sc_tdata}, 32'd2);
    step();
    chk("sc_bp_3", {16'd0, sc_tdata}, 32'd3);
    step();
    chk("sc_bp_4", {16'd0, sc_tdata}, 32'd4);
    step();
    chk("sc_bp_done", {31'd0, sc_tvalid}, 32'd0);

    // clean frame: len 20, keep FF,FF,0F
    send_frame20(16'd20, 1'b0);
    chk("f1_pkt", pkt_count, 32'd1);
    chk("f1_byte", byte_count, 32'd20);
    chk("f1_err", {16'd0, err_count}, 32'd0);
    chk("f1_led", {26'd0, led}, 32'h01);
    chk("f1_state", {31'd0, rx_state}, 32'd0);

    // same frame with tuser on tlast
    send_frame20(16'd20, 1'b1);
    chk("f2_pkt", pkt_count, 32'd2);
    chk("f2_byte", byte_count, 32'd40);
    chk("f2_err", {16'd0, err_count}, 32'd1);
    chk("f2_led", {26'd0, led}, 32'h22);

    // header says 24 bytes, payload carries 20
    send_frame20(16'd24, 1'b0);
    chk("f3_pkt", pkt_count, 32'd3);
    chk("f3_byte", byte_count, 32'd60);
`ifdef USR_RX_LEN_CHECK_EN
    chk("f3_err_lencheck", {16'd0, err_count}, 32'd2);
`else
    chk("f3_err_nocheck", {16'd0, err_count}, 32'd1);
`endif

    // payload offered before its header must stall
    p_tkeep = 8'h03; p_tlast = 1'b1; p_tuser = 1'b0; p_tvalid = 1'b1;
    repeat (3) begin
      chk("early_tready", {31'd0, p_tready}, 32'd0);
      step();
    end
    chk("early_pkt", pkt_count, 32'd3);
    send_hdr(16'd2);
    chk("early_tready_after_hdr", {31'd0, p_tready}, 32'd1);
    step();
    p_tvalid = 1'b0; p_tlast = 1'b0;
    chk("f4_pkt", pkt_count, 32'd4);
    chk("f4_byte", byte_count, 32'd62);

    // reset in the middle of a frame
    send_hdr(16'd16);
    send_beat(8'hFF, 1'b0, 1'b0);
    chk("mid_state_payload", {31'd0, rx_state}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pkt", pkt_count, 32'd0);
    chk("mid_rst_byte", byte_count, 32'd0);
    chk("mid_rst_err", {16'd0, err_count}, 32'd0);
    chk("mid_rst_state", {31'd0, rx_state}, 32'd0);
    chk("mid_rst_led", {26'd0, led}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 100 back-to-back single-beat frames
    for (int i = 0; i < 100; i++) begin
      send_hdr(16'd1);
      send_beat(8'h01, 1'b1, 1'b0);
    end
    chk("b2b_pkt", pkt_count, 32'd100);
    chk("b2b_byte", byte_count, 32'd100);
    chk("b2b_err", {16'd0, err_count}, 32'd0);
    chk("b2b_led", {26'd0, led}, 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
